traffic_controller_multi: RTL and testbench
===========================================

Name: traffic_controller_multi

Overview:
- Parametrised successor to the single-obstacle traffic controller for the car game.
- Tracks up to NUM_SLOTS concurrent traffic obstacles across NUM_LANES lanes, all on one shared speed tick.
- Adds per-lane spawn spacing, a retire-based score counter and an explicit run/over state machine.
- Sits between the LFSR/random source and the renderer/collision logic; consumes the car module's collision flag.

Parameters:
- NUM_SLOTS, 4, number of concurrent obstacle slots (1..8).
- NUM_LANES, 4, number of road lanes (2..2**LANE_W).
- LANE_W, 2, lane index width.
- Y_W, 10, vertical position width.
- Y_MAX, 480, bottom row; an obstacle at Y_MAX retires on the next tick.
- SPEED_W, 20, tick divider width.
- RAND_W, 16, random input width.
- SPAWN_THRESHOLD, 16'h8000, spawn is attempted only when rand > SPAWN_THRESHOLD.
- MIN_GAP, 64, minimum y of every active obstacle in a lane before a new spawn into that lane.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  level; high = run, low = pause (IDLE->RUN on high).
- speed  in  SPEED_W  tick period minus 1, in clk cycles.
- rand  in  RAND_W  free-running random value, sampled on tick.
- collision  in  1  car/obstacle overlap flag, sampled on tick.
- slot_active  out  NUM_SLOTS  per-slot valid.
- slot_lane  out  NUM_SLOTS*LANE_W  packed lane index; slot i at [i*LANE_W +: LANE_W].
- slot_y  out  NUM_SLOTS*Y_W  packed y; slot i at [i*Y_W +: Y_W].
- game_over  out  1  high in OVER.
- score  out  16  obstacles survived, saturating.
- tick  out  1  one-cycle pulse on each movement step.

Behaviour:
- Reset (async, any state): state=IDLE, counter=0, all slot_active=0, slot_lane=0, slot_y=0, game_over=0, score=0, tick=0. A reset mid-run discards all obstacles immediately.
- States:
  - IDLE -> RUN when start=1.
  - RUN -> OVER on a tick with collision=1.
  - OVER holds until rst; start is ignored in OVER.
- Tick generation (RUN and start=1 only):
  - If counter >= speed: counter<=0 and tick<=1 for that cycle; otherwise counter++ and tick<=0.
  - speed=0 gives a tick every cycle.
  - With start=0 in RUN, the counter and all slots freeze and tick=0.
- All tick actions are registered, so outputs update on the cycle tick is high.
- On a tick with collision=1:
  - game_over<=1, state<=OVER.
  - No movement, retire, spawn or score change on that tick.
  - Slots keep their values frozen in OVER, so the renderer can still draw the crash.
- On a tick with collision=0, per active slot:
  - y < Y_MAX: y<=y+1.
  - y == Y_MAX: active<=0, y<=0, counts as one retire.
- Score on a normal tick: score <= min(score + retire_count, 16'hFFFF). Multiple retires in one tick are all counted.
- Spawn: at most one per tick, evaluated on pre-tick state. Requires all of:
  - rand > SPAWN_THRESHOLD;
  - candidate lane L = rand[LANE_W-1:0] with L < NUM_LANES (else skip);
  - no active slot in lane L with y < MIN_GAP;
  - some slot inactive before this tick.
- The spawn target is the lowest-index inactive slot; it gets active<=1, lane<=L, y<=0.
- A slot retiring on the same tick is not eligible for reuse until the next tick.
- Width rules: y arithmetic in Y_W bits, with Y_MAX < 2**Y_W required. Score adder is 17 bits, then saturated.

Decomposition:
- Shared package traffic_pkg:
  - state enum {IDLE, RUN, OVER};
  - default Y_MAX, SPAWN_THRESHOLD, MIN_GAP constants;
  - slot field-extraction functions for the packed buses.
- One natural sub-module, traffic_tick_gen: the speed counter plus tick pulse, with enable=start in RUN.

Test Plan:
- Reset then start=1, speed=3, rand=16'hFFFF -> tick every 4 cycles; first tick spawns slot0 in lane 3 at y=0; slot0 y=5 after 6 ticks.
- Fixed rand=16'h8001 (lane 1), speed=0:
  - second spawn into lane 1 is blocked until slot0 y>=64;
  - slot1 spawns on the tick where the pre-tick slot0 y=64.
- Slot at y=480 with collision=0 -> next tick clears active and score 0->1.
- Two slots reaching 480 on the same tick -> score +2.
- collision=1 on a tick with slot0 y=100 -> game_over=1, slot0 y stays 100 forever; start toggling has no effect; rst returns all outputs to 0.
- NUM_LANES=3, rand=16'h8003 -> no spawn (lane 3 invalid).
- All NUM_SLOTS active with rand=16'hFFFF -> no spawn and no overwrite.
- start dropped mid-run for 10 cycles -> slot_y and counter frozen; resume continues from the same count.
- score preloaded near 16'hFFFE via forced retires -> saturates at 16'hFFFF.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types, default constants and packed-bus helpers for the multi-slot
// traffic controller.
package traffic_pkg;

   typedef enum logic [1:0] {IDLE, RUN, OVER} state_e;

   localparam int unsigned DEF_Y_MAX           = 480;
   localparam int unsigned DEF_SPAWN_THRESHOLD = 32'h8000;
   localparam int unsigned DEF_MIN_GAP         = 64;

   // Widest packed slot bus the field helper accepts; callers zero-extend.
   localparam int unsigned FIELD_BUS_W = 256;

   // Returns field idx of width w (w < 32) from a packed per-slot bus.
   function automatic logic [31:0] slot_field(input logic [FIELD_BUS_W-1:0] bus,
                                              input int unsigned idx,
                                              input int unsigned w);
      logic [FIELD_BUS_W-1:0] sh;
      sh = bus >> (idx * w);
      return sh[31:0] & ((32'd1 << w) - 32'd1);
   endfunction

endpackage

// File: rtl/traffic_tick_gen.sv
// Speed divider: fire is the combinational step strobe, tick its registered
// one-cycle pulse so downstream state and tick change on the same edge.
module traffic_tick_gen
   import traffic_pkg::*;
#(
   parameter int unsigned SPEED_W = 20
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic [SPEED_W-1:0] speed,
   output logic               fire,
   output logic               tick
);

   logic [SPEED_W-1:0] count_q, count_d;
   logic               tick_d;

   assign fire = enable && (count_q >= speed);

   always_comb begin
      count_d = count_q;
      tick_d  = 1'b0;
      if (fire) begin
         count_d = '0;
         tick_d  = 1'b1;
      end else if (enable) begin
         count_d = count_q + SPEED_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         tick    <= 1'b0;
      end else begin
         count_q <= count_d;
         tick    <= tick_d;
      end
   end

endmodule

// File: rtl/traffic_controller_multi.sv
// Multi-slot obstacle controller: moves, retires and spawns obstacles on a
// shared speed tick and runs the IDLE/RUN/OVER game state.
module traffic_controller_multi
   import traffic_pkg::*;
#(
   parameter int unsigned NUM_SLOTS       = 4,
   parameter int unsigned NUM_LANES       = 4,
   parameter int unsigned LANE_W          = 2,
   parameter int unsigned Y_W             = 10,
   parameter int unsigned Y_MAX           = DEF_Y_MAX,
   parameter int unsigned SPEED_W         = 20,
   parameter int unsigned RAND_W          = 16,
   parameter int unsigned SPAWN_THRESHOLD = DEF_SPAWN_THRESHOLD,
   parameter int unsigned MIN_GAP         = DEF_MIN_GAP
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [SPEED_W-1:0]          speed,
   input  logic [RAND_W-1:0]           rand_val,
   input  logic                        collision,
   output logic [NUM_SLOTS-1:0]        slot_active,
   output logic [NUM_SLOTS*LANE_W-1:0] slot_lane,
   output logic [NUM_SLOTS*Y_W-1:0]    slot_y,
   output logic                        game_over,
   output logic [15:0]                 score,
   output logic                        tick
);

   localparam int unsigned       CNT_W  = $clog2(NUM_SLOTS + 1);
   localparam logic [Y_W-1:0]    Y_LAST = Y_W'(Y_MAX);
   localparam logic [Y_W-1:0]    GAP    = Y_W'(MIN_GAP);
   localparam logic [RAND_W-1:0] THRESH = RAND_W'(SPAWN_THRESHOLD);

   state_e               state_q, state_d;
   logic                 run_en, fire;
   logic [NUM_SLOTS-1:0] active_q, active_d;
   logic [LANE_W-1:0]    lane_q [NUM_SLOTS];
   logic [LANE_W-1:0]    lane_d [NUM_SLOTS];
   logic [Y_W-1:0]       y_q    [NUM_SLOTS];
   logic [Y_W-1:0]       y_d    [NUM_SLOTS];
   logic [15:0]          score_q, score_d;

   logic [LANE_W-1:0]    cand_lane;
   logic                 lane_ok, lane_blocked, have_free, spawn;
   logic [NUM_SLOTS-1:0] free_mask, target;
   logic [CNT_W-1:0]     retire_cnt;
   logic [16:0]          score_sum;

   assign run_en = (state_q == RUN) && start;

   traffic_tick_gen #(
      .SPEED_W (SPEED_W)
   ) u_tick_gen (
      .clk    (clk),
      .rst    (rst),
      .enable (run_en),
      .speed  (speed),
      .fire   (fire),
      .tick   (tick)
   );

   // Spawn decision uses pre-tick state only, so a slot retiring this tick
   // is still counted as occupied.
   assign cand_lane = rand_val[LANE_W-1:0];
   assign lane_ok   = 32'(cand_lane) < NUM_LANES;
   assign free_mask = ~active_q;
   assign have_free = |free_mask;
   assign target    = free_mask & (~free_mask + NUM_SLOTS'(1));

   always_comb begin
      lane_blocked = 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (active_q[i] && (lane_q[i] == cand_lane) && (y_q[i] < GAP)) begin
            lane_blocked = 1'b1;
         end
      end
   end

   assign spawn = (rand_val > THRESH) && lane_ok && !lane_blocked && have_free;

   always_comb begin
      state_d    = state_q;
      active_d   = active_q;
      lane_d     = lane_q;
      y_d        = y_q;
      retire_cnt = '0;

      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (fire && collision) state_d = OVER;
         OVER:    state_d = OVER;
         default: state_d = IDLE;
      endcase

      if (fire && !collision) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (active_q[i]) begin
               if (y_q[i] == Y_LAST) begin
                  active_d[i] = 1'b0;
                  y_d[i]      = '0;
                  retire_cnt  = retire_cnt + CNT_W'(1);
               end else begin
                  y_d[i] = y_q[i] + Y_W'(1);
               end
            end else if (spawn && target[i]) begin
               active_d[i] = 1'b1;
               lane_d[i]   = cand_lane;
               y_d[i]      = '0;
            end
         end
      end

      // retire_cnt is zero unless a clean tick fires, so this holds otherwise.
      score_sum = {1'b0, score_q} + 17'(retire_cnt);
      score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         active_q <= '0;
         score_q  <= '0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            lane_q[i] <= '0;
            y_q[i]    <= '0;
         end
      end else begin
         state_q <= state_d;
         if (fire) begin
            active_q <= active_d;
            lane_q   <= lane_d;
            y_q      <= y_d;
            score_q  <= score_d;
         end
      end
   end

   for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
      assign slot_lane[g*LANE_W +: LANE_W] = lane_q[g];
      assign slot_y[g*Y_W +: Y_W]          = y_q[g];
   end

   assign slot_active = active_q;
   assign game_over   = (state_q == OVER);
   assign score       = score_q;

endmodule

// File: tb/tb_traffic_controller_multi.sv
// Directed bench for traffic_controller_multi: spawn-rule vector table plus
// hand-written spacing, retire, crash, pause and saturation sequences.
module tb_traffic_controller_multi;
   import traffic_pkg::*;

   localparam int unsigned YW = 10;
   localparam int unsigned LW = 2;

   logic        clk = 1'b0;
   logic        rst, start, collision;
   logic [19:0] speed;
   logic [15:0] rnd, rnd3;
   logic [3:0]  slot_active, active3;
   logic [7:0]  slot_lane, lane3;
   logic [39:0] slot_y, y3;
   logic        game_over, go3, tick, tick3;
   logic [15:0] score, score3;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   traffic_controller_multi #(.NUM_SLOTS(4), .NUM_LANES(4)) dut (
      .clk(clk), .rst(rst), .start(start), .speed(speed), .rand_val(rnd),
      .collision(collision), .slot_active(slot_active), .slot_lane(slot_lane),
      .slot_y(slot_y), .game_over(game_over), .score(score), .tick(tick)
   );

   traffic_controller_multi #(.NUM_SLOTS(4), .NUM_LANES(3)) dut3 (
      .clk(clk), .rst(rst), .start(start), .speed(speed), .rand_val(rnd3),
      .collision(collision), .slot_active(active3), .slot_lane(lane3),
      .slot_y(y3), .game_over(go3), .score(score3), .tick(tick3)
   );

   typedef struct {
      logic [15:0] rnd;
      logic [3:0]  act;
      logic [7:0]  lanes;
      logic [9:0]  y0;
   } vec_t;

   vec_t vecs [9];

   function automatic logic [31:0] y_of(input int unsigned i);
      return slot_field(FIELD_BUS_W'(slot_y), i, YW);
   endfunction

   function automatic logic [31:0] lane_of(input int unsigned i);
      return slot_field(FIELD_BUS_W'(slot_lane), i, LW);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_tick(input string name, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!tick && n < 64);
      if (!tick) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: no tick within 64 cycles", name);
      end
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      start     = 1'b0;
      collision = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n;
      logic bad;
      logic [39:0] y_hold;

      vecs[0] = '{16'h0000, 4'h0, 8'h00, 10'd0};
      vecs[1] = '{16'h8000, 4'h0, 8'h00, 10'd0};
      vecs[2] = '{16'h8002, 4'h1, 8'h02, 10'd0};
      vecs[3] = '{16'hFFFE, 4'h1, 8'h02, 10'd1};
      vecs[4] = '{16'h8004, 4'h3, 8'h02, 10'd2};
      vecs[5] = '{16'hFFFF, 4'h7, 8'h32, 10'd3};
      vecs[6] = '{16'h7FFF, 4'h7, 8'h32, 10'd4};
      vecs[7] = '{16'h8005, 4'hF, 8'h72, 10'd5};
      vecs[8] = '{16'hFFFD, 4'hF, 8'h72, 10'd6};

      speed = '0;
      rnd   = '0;
      rnd3  = '0;

      // Reset state, then speed=3: tick every 4 cycles, lane-3 spawn.
      do_reset();
      check("reset_active", 32'(slot_active), 32'h0);
      check("reset_y", 32'(slot_y), 32'h0);
      check("reset_lane", 32'(slot_lane), 32'h0);
      check("reset_score", 32'(score), 32'h0);
      check("reset_game_over", 32'(game_over), 32'h0);
      check("reset_tick", 32'(tick), 32'h0);

      speed = 20'd3;
      rnd   = 16'hFFFF;
      start = 1'b1;
      wait_tick("a_tick1", n);
      check("a_first_latency", 32'(n), 32'd5);
      check("a_spawn_active", 32'(slot_active), 32'h1);
      check("a_spawn_lane", lane_of(0), 32'd3);
      check("a_spawn_y", y_of(0), 32'd0);
      for (int k = 2; k <= 6; k++) begin
         wait_tick("a_tick", n);
         check("a_period", 32'(n), 32'd4);
      end
      check("a_y_after6", y_of(0), 32'd5);
      check("a_lane_blocked", 32'(slot_active), 32'h1);

      // Pause two cycles into a period; resume must finish the same count.
      step();
      step();
      start  = 1'b0;
      y_hold = slot_y;
      bad    = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (tick || slot_y !== y_hold) bad = 1'b1;
      end
      check("a_pause_frozen", 32'(bad), 32'h0);
      start = 1'b1;
      wait_tick("a_resume", n);
      check("a_resume_latency", 32'(n), 32'd2);
      check("a_resume_y", y_of(0), 32'd6);

      // Lane-1 spacing, full table, retire and slot reuse at speed=0.
      do_reset();
      speed = 20'd0;
      rnd   = 16'h8001;
      start = 1'b1;
      for (int t = 1; t <= 547; t++) begin
         wait_tick("b_tick", n);
         case (t)
            65: begin
               check("b65_active", 32'(slot_active), 32'h1);
               check("b65_y0", y_of(0), 32'd64);
            end
            66: begin
               check("b66_active", 32'(slot_active), 32'h3);
               check("b66_lane1", lane_of(1), 32'd1);
               check("b66_y1", y_of(1), 32'd0);
               check("b66_y0", y_of(0), 32'd65);
            end
            131: check("b131_active", 32'(slot_active), 32'h7);
            196: check("b196_active", 32'(slot_active), 32'hF);
            261: begin
               check("b261_full_active", 32'(slot_active), 32'hF);
               check("b261_y0", y_of(0), 32'd260);
               check("b261_y3", y_of(3), 32'd65);
            end
            481: check("b481_y0", y_of(0), 32'd480);
            482: begin
               check("b482_active", 32'(slot_active), 32'hE);
               check("b482_score", 32'(score), 32'd1);
               check("b482_y0", y_of(0), 32'd0);
            end
            483: begin
               check("b483_reuse", 32'(slot_active), 32'hF);
               check("b483_lane0", lane_of(0), 32'd1);
               check("b483_score", 32'(score), 32'd1);
            end
            547: begin
               check("b547_active", 32'(slot_active), 32'hD);
               check("b547_score", 32'(score), 32'd2);
            end
            default: ;
         endcase
      end

      // Crash at y0=100, then OVER ignores start; reset clears everything.
      do_reset();
      speed = 20'd0;
      rnd   = 16'hFFFF;
      start = 1'b1;
      for (int t = 1; t <= 101; t++) wait_tick("c_tick", n);
      check("c_y0_pre", y_of(0), 32'd100);
      collision = 1'b1;
      wait_tick("c_crash", n);
      collision = 1'b0;
      check("c_game_over", 32'(game_over), 32'h1);
      check("c_active", 32'(slot_active), 32'h3);
      check("c_y0", y_of(0), 32'd100);
      check("c_y1", y_of(1), 32'd35);
      check("c_score", 32'(score), 32'd0);
      bad = 1'b0;
      for (int k = 0; k < 20; k++) begin
         start = k[1];
         step();
         if (tick || !game_over || y_of(0) != 32'd100) bad = 1'b1;
      end
      check("c_over_hold", 32'(bad), 32'h0);
      #3 rst = 1'b1;
      #1;
      check("c_rst_game_over", 32'(game_over), 32'h0);
      check("c_rst_active", 32'(slot_active), 32'h0);
      check("c_rst_y", 32'(slot_y), 32'h0);
      check("c_rst_lane", 32'(slot_lane), 32'h0);

      // Spawn-rule vector table.
      do_reset();
      speed = 20'd0;
      rnd   = 16'h0000;
      start = 1'b1;
      step();
      for (int v = 0; v < 9; v++) begin
         rnd = vecs[v].rnd;
         step();
         check("t_tick", 32'(tick), 32'h1);
         check("t_active", 32'(slot_active), 32'(vecs[v].act));
         check("t_lanes", 32'(slot_lane), 32'(vecs[v].lanes));
         check("t_y0", y_of(0), 32'(vecs[v].y0));
      end
      #3 rst = 1'b1;
      #1;
      check("t_midrun_rst_active", 32'(slot_active), 32'h0);
      check("t_midrun_rst_y", 32'(slot_y), 32'h0);

      // Three-lane instance: lane index 3 is never spawned.
      do_reset();
      speed = 20'd0;
      rnd   = 16'h0000;
      rnd3  = 16'h8003;
      start = 1'b1;
      for (int k = 0; k < 6; k++) step();
      check("l3_ticking", 32'(tick3), 32'h1);
      check("l3_no_spawn", 32'(active3), 32'h0);
      rnd3 = 16'h8002;
      step();
      check("l3_spawn_lane2", 32'(active3), 32'h1);
      check("l3_lane", 32'(lane3[1:0]), 32'd2);

      // Double retire on one tick, then saturation from a preloaded score.
      do_reset();
      speed = 20'd0;
      start = 1'b1;
      rnd   = 16'hFFFC;
      step();
      step();
      rnd = 16'hFFFD;
      step();
      rnd   = 16'h0000;
      start = 1'b0;
      step();
      check("d_two_active", 32'(slot_active), 32'h3);
      dut.y_q[0] = 10'd480;
      dut.y_q[1] = 10'd480;
      step();
      start = 1'b1;
      step();
      check("d_double_retire_active", 32'(slot_active), 32'h0);
      check("d_double_retire_score", 32'(score), 32'd2);

      rnd = 16'hFFFC;
      step();
      rnd = 16'hFFFD;
      step();
      rnd   = 16'h0000;
      start = 1'b0;
      step();
      dut.y_q[0]    = 10'd480;
      dut.y_q[1]    = 10'd480;
      dut.score_q   = 16'hFFFE;
      step();
      start = 1'b1;
      step();
      check("s_saturate", 32'(score), 32'hFFFF);
      check("s_active", 32'(slot_active), 32'h0);
      rnd = 16'hFFFC;
      step();
      rnd   = 16'h0000;
      start = 1'b0;
      step();
      dut.y_q[0] = 10'd480;
      step();
      start = 1'b1;
      step();
      check("s_stay_saturated", 32'(score), 32'hFFFF);
      check("s_active2", 32'(slot_active), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
